// File: rtl/alu_wb_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the execute/writeback controller.
package alu_wb_pkg;

    localparam int DEF_DATA_W   = 3;
    localparam int DEF_ADDR_W   = 2;
    localparam int DEF_NUM_REGS = 3;
    localparam int OP_W         = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB = 3'b001;
    localparam logic [OP_W-1:0] OP_AND = 3'b010;
    localparam logic [OP_W-1:0] OP_OR  = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR = 3'b100;
    localparam logic [OP_W-1:0] OP_NOT = 3'b101;
    localparam logic [OP_W-1:0] OP_MOV = 3'b110;
    localparam logic [OP_W-1:0] OP_NOP = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_wb_ctrl_if.sv
// Op request handshake plus register-file read/write and status signals of the controller.
interface alu_wb_ctrl_if
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);
    logic              op_valid;
    logic              op_ready;
    logic [OP_W-1:0]   op_code;
    logic [ADDR_W-1:0] op_src1;
    logic [ADDR_W-1:0] op_src2;
    logic [ADDR_W-1:0] op_dst;
    logic [ADDR_W-1:0] rd_reg1;
    logic [ADDR_W-1:0] rd_reg2;
    logic [DATA_W-1:0] reg_data1;
    logic [DATA_W-1:0] reg_data2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] result;
    logic              carry;
    logic              done;
    logic              err;

    modport master (
        output op_valid, op_code, op_src1, op_src2, op_dst, reg_data1, reg_data2,
        input  op_ready, rd_reg1, rd_reg2, wr_en, wr_reg, wr_data, result, carry, done, err
    );

    modport slave (
        input  op_valid, op_code, op_src1, op_src2, op_dst, reg_data1, reg_data2,
        output op_ready, rd_reg1, rd_reg2, wr_en, wr_reg, wr_data, result, carry, done, err
    );

endinterface

// File: rtl/alu_wb_ctrl_alu_core.sv
// Combinational ALU: {carry,result} from opcode and two operands, modulo 2^DATA_W.
module alu_core
    import alu_wb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        // Top bit of the widened difference is set exactly when a < b.
        diff   = {1'b0, a} - {1'b0, b};
        result = '0;
        carry  = 1'b0;
        case (op_code)
            OP_ADD: {carry, result} = sum;
            OP_SUB: {carry, result} = diff;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            OP_MOV: result = a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_wb_ctrl.sv
// Execute/writeback controller: accepts one op, reads operands, computes, writes back, retires.
module alu_wb_ctrl
    import alu_wb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_REGS = DEF_NUM_REGS
) (
    input logic          clk,
    input logic          rst,
    alu_wb_ctrl_if.slave bus
);
    localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);

    state_e            state_q,   state_d;
    logic [OP_W-1:0]   code_q,    code_d;
    logic [ADDR_W-1:0] dst_q,     dst_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] op_a_q,    op_a_d;
    logic [DATA_W-1:0] op_b_q,    op_b_d;
    logic [ADDR_W-1:0] rd_reg1_q, rd_reg1_d;
    logic [ADDR_W-1:0] rd_reg2_q, rd_reg2_d;
    logic              wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0] wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [DATA_W-1:0] result_q,  result_d;
    logic              carry_q,   carry_d;
    logic              done_q,    done_d;
    logic              err_q,     err_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;

    alu_core #(.DATA_W(DATA_W)) u_alu_core (
        .op_code (code_q),
        .a       (op_a_q),
        .b       (op_b_q),
        .result  (alu_result),
        .carry   (alu_carry)
    );

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        dst_d     = dst_q;
        illegal_d = illegal_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rd_reg1_d = rd_reg1_q;
        rd_reg2_d = rd_reg2_q;
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        result_d  = result_q;
        carry_d   = carry_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.op_valid) begin
                    code_d    = bus.op_code;
                    dst_d     = bus.op_dst;
                    rd_reg1_d = bus.op_src1;
                    rd_reg2_d = bus.op_src2;
                    illegal_d = ({1'b0, bus.op_src1} >= NUM_REGS_L) ||
                                ({1'b0, bus.op_src2} >= NUM_REGS_L) ||
                                ({1'b0, bus.op_dst}  >= NUM_REGS_L);
                    state_d   = ST_READ;
                end
            end
            ST_READ: begin
                op_a_d  = bus.reg_data1;
                op_b_d  = bus.reg_data2;
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                // Outputs computed here become visible during the WB cycle.
                done_d = 1'b1;
                err_d  = illegal_q;
                if (!illegal_q && code_q != OP_NOP) begin
                    result_d  = alu_result;
                    carry_d   = alu_carry;
                    wr_en_d   = 1'b1;
                    wr_reg_d  = dst_q;
                    wr_data_d = alu_result;
                end
                state_d = ST_WB;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            code_q    <= OP_NOP;
            dst_q     <= '0;
            illegal_q <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            rd_reg1_q <= '0;
            rd_reg2_q <= '0;
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
            result_q  <= '0;
            carry_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            code_q    <= code_d;
            dst_q     <= dst_d;
            illegal_q <= illegal_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rd_reg1_q <= rd_reg1_d;
            rd_reg2_q <= rd_reg2_d;
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
            result_q  <= result_d;
            carry_q   <= carry_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign bus.op_ready = (state_q == ST_IDLE) && !rst;
    assign bus.rd_reg1  = rd_reg1_q;
    assign bus.rd_reg2  = rd_reg2_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_reg   = wr_reg_q;
    assign bus.wr_data  = wr_data_q;
    assign bus.result   = result_q;
    assign bus.carry    = carry_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_alu_wb_ctrl.sv
// Directed bench for alu_wb_ctrl with a 3-entry register file model around it.
module tb_alu_wb_ctrl;
    import alu_wb_pkg::*;

    localparam int DW = 3;
    localparam int AW = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_wb_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    alu_wb_ctrl #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [DW-1:0] rf [0:2];
    logic          pre_en;
    logic [AW-1:0] pre_idx;
    logic [DW-1:0] pre_val;

    always @(posedge clk) begin
        if (pre_en)
            rf[pre_idx] <= pre_val;
        else if (bus.wr_en && bus.wr_reg < 2'd3)
            rf[bus.wr_reg] <= bus.wr_data;
    end

    always @(negedge clk) begin
        bus.reg_data1 <= (bus.rd_reg1 < 2'd3) ? rf[bus.rd_reg1] : '0;
        bus.reg_data2 <= (bus.rd_reg2 < 2'd3) ? rf[bus.rd_reg2] : '0;
    end

    int vecs = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] idx, input logic [DW-1:0] val);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        tick();
        pre_en  = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] code,
                          input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic [AW-1:0] d,
                          input logic exp_wr, input logic exp_err,
                          input logic [DW-1:0] exp_res, input logic exp_c);
        bus.op_valid = 1'b1;
        bus.op_code  = code;
        bus.op_src1  = s1;
        bus.op_src2  = s2;
        bus.op_dst   = d;
        tick();
        bus.op_valid = 1'b0;
        check({tag, ".rd_reg1"}, 8'(bus.rd_reg1), 8'(s1));
        check({tag, ".rd_reg2"}, 8'(bus.rd_reg2), 8'(s2));
        check({tag, ".busy"}, 8'(bus.op_ready), 8'd0);
        tick();
        tick();
        check({tag, ".wr_en"}, 8'(bus.wr_en), 8'(exp_wr));
        check({tag, ".done"}, 8'(bus.done), 8'd1);
        check({tag, ".err"}, 8'(bus.err), 8'(exp_err));
        check({tag, ".result"}, 8'(bus.result), 8'(exp_res));
        if (exp_wr) begin
            check({tag, ".wr_reg"}, 8'(bus.wr_reg), 8'(d));
            check({tag, ".wr_data"}, 8'(bus.wr_data), 8'(exp_res));
        end
        if (exp_wr || exp_err)
            check({tag, ".carry"}, 8'(bus.carry), 8'(exp_c));
        tick();
        check({tag, ".wr_en_off"}, 8'(bus.wr_en), 8'd0);
        check({tag, ".done_off"}, 8'(bus.done), 8'd0);
        check({tag, ".ready"}, 8'(bus.op_ready), 8'd1);
        $display("op %s code=%0d src=%0d,%0d dst=%0d -> wr_en=%0d data=%0d carry=%0d err=%0d",
                 tag, code, s1, s2, d, exp_wr, exp_res, exp_c, exp_err);
    endtask

    initial begin
        rst          = 1'b1;
        pre_en       = 1'b0;
        pre_idx      = '0;
        pre_val      = '0;
        bus.op_valid = 1'b0;
        bus.op_code  = OP_NOP;
        bus.op_src1  = '0;
        bus.op_src2  = '0;
        bus.op_dst   = '0;

        tick();
        tick();
        check("rst.wr_en", 8'(bus.wr_en), 8'd0);
        check("rst.done", 8'(bus.done), 8'd0);
        check("rst.ready", 8'(bus.op_ready), 8'd0);
        check("rst.result", 8'(bus.result), 8'd0);
        check("rst.carry", 8'(bus.carry), 8'd0);
        rst = 1'b0;
        #1;
        check("rst.ready_after", 8'(bus.op_ready), 8'd1);
        $display("reset released");

        preload(2'd0, 3'd3);
        preload(2'd1, 3'd6);
        preload(2'd2, 3'd0);
        run_op("add", OP_ADD, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd1, 1'b1);
        check("add.rf2", 8'(rf[2]), 8'd1);

        preload(2'd0, 3'd2);
        preload(2'd1, 3'd5);
        run_op("sub_borrow", OP_SUB, 2'd0, 2'd1, 2'd1, 1'b1, 1'b0, 3'd5, 1'b1);
        run_op("mov", OP_MOV, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 3'd5, 1'b0);
        check("mov.rf0", 8'(rf[0]), 8'd5);

        preload(2'd0, 3'd6);
        preload(2'd1, 3'd3);
        run_op("and", OP_AND, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd2, 1'b0);
        run_op("or",  OP_OR,  2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd7, 1'b0);
        run_op("xor", OP_XOR, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd5, 1'b0);
        run_op("not", OP_NOT, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd1, 1'b0);
        run_op("sub", OP_SUB, 2'd0, 2'd1, 2'd2, 1'b1, 1'b0, 3'd3, 1'b0);

        run_op("ill_dst", OP_ADD, 2'd0, 2'd1, 2'd3, 1'b0, 1'b1, 3'd3, 1'b0);
        run_op("ill_src", OP_XOR, 2'd3, 2'd1, 2'd2, 1'b0, 1'b1, 3'd3, 1'b0);
        check("ill.rf0", 8'(rf[0]), 8'd6);
        check("ill.rf1", 8'(rf[1]), 8'd3);
        check("ill.rf2", 8'(rf[2]), 8'd3);

        // Back-to-back: op_valid held high across two ops.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_MOV;
        bus.op_src1  = 2'd0;
        bus.op_src2  = 2'd0;
        bus.op_dst   = 2'd2;
        tick();
        bus.op_src1  = 2'd1;
        check("b2b.ready0", 8'(bus.op_ready), 8'd0);
        tick();
        check("b2b.ready1", 8'(bus.op_ready), 8'd0);
        tick();
        check("b2b.ready2", 8'(bus.op_ready), 8'd0);
        check("b2b.first_wr_data", 8'(bus.wr_data), 8'd6);
        tick();
        check("b2b.ready3", 8'(bus.op_ready), 8'd1);
        check("b2b.no_early_accept", 8'(bus.rd_reg1), 8'd0);
        tick();
        bus.op_valid = 1'b0;
        check("b2b.second_accept", 8'(bus.rd_reg1), 8'd1);
        check("b2b.ready4", 8'(bus.op_ready), 8'd0);
        tick();
        tick();
        check("b2b.second_wr_en", 8'(bus.wr_en), 8'd1);
        check("b2b.second_wr_data", 8'(bus.wr_data), 8'd3);
        tick();
        $display("back-to-back ops retired");

        // Reset while the op sits in EXEC.
        bus.op_valid = 1'b1;
        bus.op_code  = OP_ADD;
        bus.op_src1  = 2'd0;
        bus.op_src2  = 2'd1;
        bus.op_dst   = 2'd2;
        tick();
        bus.op_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rst_exec.wr_en", 8'(bus.wr_en), 8'd0);
        check("rst_exec.done", 8'(bus.done), 8'd0);
        check("rst_exec.ready", 8'(bus.op_ready), 8'd0);
        check("rst_exec.rd_reg1", 8'(bus.rd_reg1), 8'd0);
        check("rst_exec.result", 8'(bus.result), 8'd0);
        rst = 1'b0;
        #1;
        check("rst_exec.ready_after", 8'(bus.op_ready), 8'd1);
        tick();
        check("rst_exec.wr_en_after", 8'(bus.wr_en), 8'd0);
        check("rst_exec.rf2", 8'(rf[2]), 8'd3);
        $display("reset during EXEC dropped op");

        run_op("after_rst", OP_SUB, 2'd1, 2'd0, 2'd0, 1'b1, 1'b0, 3'd5, 1'b1);
        run_op("nop", OP_NOP, 2'd0, 2'd0, 2'd0, 1'b0, 1'b0, 3'd5, 1'b0);
        check("nop.rf0", 8'(rf[0]), 8'd5);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
